// File: rtl/logger_pkg.sv
// Purpose: shared types and constants for the logger UART transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package logger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    // Level of the serial line between frames and during the stop bit.
    localparam logic       UART_IDLE_LVL = 1'b1;

    // Index of the final data bit (8 data bits, LSB first).
    localparam logic [2:0] LAST_BIT_IDX  = 3'd7;

endpackage

// File: rtl/logger_uart_tx_if.sv
// Purpose: read-side bundle of the logger sync FIFO (standard, non-FWFT).
// Latency: fifo_dout is valid the cycle after a fifo_rd_en pulse.
// Backpressure: the reader only pulses fifo_rd_en while fifo_empty is low.
interface logger_uart_tx_if;

    logic       fifo_rd_en;
    logic [7:0] fifo_dout;
    logic       fifo_empty;

    // Reader side (the UART transmitter).
    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_empty
    );

    // FIFO side.
    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_empty
    );

endinterface

// File: rtl/logger_uart_tx.sv
// Purpose: drains bytes from the logger sync FIFO onto an 8N1 UART line, LSB first, idle high.
// Latency: start bit begins two edges after the read pulse; each frame spans 10*CLKS_PER_BIT cycles.
// Backpressure: reads only in IDLE with tx_en high and FIFO non-empty; a started frame always completes.
module logger_uart_tx
    import logger_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst_n,
    logger_uart_tx_if.master fifo,
    input  logic             tx_en,
    output logic             uart_txd,
    output logic             tx_busy,
    output logic             byte_done
);

    localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [2:0]       w_idx_inc;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_txd;
    logic             w_txd_nxt;
    logic             w_bit_end;
    logic             w_rd_req;

    // Counter sits at its top value on the last cycle of every bit period.
    assign w_bit_end = (r_cnt == CNT_TOP);
    assign w_idx_inc = r_idx + 3'd1;

    // Next-state and next-line-level logic; the line value is registered so it
    // always reflects the bit of the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_rd_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_txd_nxt = UART_IDLE_LVL;
                w_rd_req  = tx_en && !fifo.fifo_empty;
                if (w_rd_req) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Byte is frozen here; later fifo_dout activity is irrelevant.
                w_shift_nxt = fifo.fifo_dout;
                w_cnt_nxt   = '0;
                w_txd_nxt   = ~UART_IDLE_LVL;
                w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_txd_nxt   = r_shift[0];
                    w_state_nxt = ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == LAST_BIT_IDX) begin
                        w_txd_nxt   = UART_IDLE_LVL;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_txd_nxt = r_shift[w_idx_inc];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_txd_nxt   = UART_IDLE_LVL;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset truncates any frame and parks the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_txd   <= UART_IDLE_LVL;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // Read pulse is gated by reset so the FIFO is never popped while held in reset.
    assign fifo.fifo_rd_en = w_rd_req & rst_n;
    assign uart_txd        = r_txd;
    assign tx_busy         = (r_state != ST_IDLE);
    assign byte_done       = (r_state == ST_STOP) && w_bit_end;

endmodule

// File: tb/tb_logger_uart_tx.sv
// Purpose: self-checking bench for logger_uart_tx with CLKS_PER_BIT=4.
// Latency: n/a.
// Backpressure: FIFO model pops only on a read pulse while non-empty.
module tb_logger_uart_tx;

    localparam int CLKS  = 4;
    localparam int MID   = CLKS / 2;
    localparam int FRAME = 10 * CLKS + 2;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic tx_en    = 1'b0;
    logic uart_txd;
    logic tx_busy;
    logic byte_done;

    logger_uart_tx_if fifo_if ();

    logger_uart_tx #(.CLKS_PER_BIT(CLKS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fifo     (fifo_if),
        .tx_en    (tx_en),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy),
        .byte_done(byte_done)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model (standard read latency) ----------------
    logic [7:0] mem [0:1023];
    int         n_push  = 0;
    int         n_pop   = 0;
    logic [7:0] r_dout  = 8'h00;
    bit         corrupt = 1'b0;

    always @(posedge clk) begin
        if (fifo_if.fifo_rd_en && (n_pop != n_push)) begin
            r_dout <= mem[10'(n_pop)];
            n_pop  <= n_pop + 1;
        end
    end

    assign fifo_if.fifo_dout  = corrupt ? 8'hFF : r_dout;
    assign fifo_if.fifo_empty = (n_push == n_pop);

    // ---------------- Line monitor and UART receiver ----------------
    int         cyc       = 0;
    bit         line_q [$];
    bit         busy_q [$];
    int         rd_q   [$];
    int         done_q [$];
    logic [7:0] rx_b   [$];
    int         rx_s   [$];
    bit         in_frame  = 1'b0;
    bit         prev_txd  = 1'b1;
    int         st        = 0;
    logic [7:0] acc       = 8'h00;
    int         frame_err = 0;

    // Samples once per cycle on the falling edge; decodes frames by mid-bit sampling.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        line_q.push_back(uart_txd);
        busy_q.push_back(tx_busy);
        if (fifo_if.fifo_rd_en) rd_q.push_back(cyc);
        if (byte_done) done_q.push_back(cyc);
        prev_txd <= uart_txd;
        if (!rst_n) begin
            in_frame <= 1'b0;
        end else if (!in_frame) begin
            if (prev_txd && !uart_txd) begin
                in_frame <= 1'b1;
                st       <= cyc;
                acc      <= 8'h00;
            end
        end else begin
            if (cyc - st == MID) begin
                if (uart_txd) begin
                    frame_err <= frame_err + 1;
                    in_frame  <= 1'b0;
                end
            end else if ((cyc - st >= CLKS + MID) && (cyc - st <= 8 * CLKS + MID) &&
                         ((cyc - st - MID) % CLKS == 0)) begin
                acc[3'((cyc - st - MID) / CLKS - 1)] <= uart_txd;
            end else if (cyc - st == 9 * CLKS + MID) begin
                in_frame <= 1'b0;
                if (uart_txd) begin
                    rx_b.push_back(acc);
                    rx_s.push_back(st);
                end else begin
                    frame_err <= frame_err + 1;
                end
            end
        end
    end

    // ---------------- Checking helpers ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Inputs change 1 ns after the rising edge; the monitor samples on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[10'(n_push)] = b;
        n_push = n_push + 1;
    endtask

    task automatic wait_rd(output int r, output bit ok);
        int n0;
        n0 = rd_q.size();
        ok = 1'b0;
        r  = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (rd_q.size() > n0) begin
                ok = 1'b1;
                r  = rd_q[n0];
            end
        end
    endtask

    task automatic wait_rx(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (rx_b.size() >= target) ok = 1'b1;
            else step();
        end
        if (rx_b.size() >= target) ok = 1'b1;
    endtask

    // Sends one byte from an idle DUT and checks the exact line waveform cycle by cycle.
    task automatic send_check(input logic [7:0] din, input logic [9:0] line);
        int         r;
        bit         ok;
        int         rd0, dn0, rx0, b;
        logic [3:0] seg;
        rd0 = rd_q.size();
        dn0 = done_q.size();
        rx0 = rx_b.size();
        push(din);
        wait_rd(r, ok);
        chk($sformatf("v%02h_rd_seen", din), int'(ok), 1);
        if (ok) begin
            while (line_q.size() <= r + FRAME + 1) step();
            chk($sformatf("v%02h_rd_pulses", din), rd_q.size() - rd0, 1);
            chk($sformatf("v%02h_load_idle", din), int'(line_q[r + 1]), 1);
            for (int j = 0; j < 10; j++) begin
                b = r + 2 + CLKS * j;
                for (int c = 0; c < 4; c++) seg[c] = line_q[b + c];
                chk($sformatf("v%02h_bit%0d", din, j), int'(seg), int'({4{line[9 - j]}}));
            end
            chk($sformatf("v%02h_gap_idle", din), int'(line_q[r + FRAME]), 1);
            chk($sformatf("v%02h_done_cnt", din), done_q.size() - dn0, 1);
            if (done_q.size() > dn0)
                chk($sformatf("v%02h_done_cyc", din), done_q[dn0] - r, FRAME - 1);
            chk($sformatf("v%02h_busy_load", din), int'(busy_q[r + 1]), 1);
            chk($sformatf("v%02h_busy_after", din), int'(busy_q[r + FRAME]), 0);
            chk($sformatf("v%02h_rx_cnt", din), rx_b.size() - rx0, 1);
            if (rx_b.size() > rx0) chk($sformatf("v%02h_rx_byte", din), int'(rx_b[rx0]), int'(din));
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic [9:0] line;   // line[9] is the start bit, line[0] the stop bit
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] rec  [56];
    logic [7:0] exp_q [$];

    initial begin
        int r, c, l0, rd0, rx0, bad, minsp;
        bit ok;
        logic [7:0] b;

        vecs[0] = '{8'h41, 10'b0100000101};
        vecs[1] = '{8'h00, 10'b0000000001};
        vecs[2] = '{8'hFF, 10'b0111111111};
        vecs[3] = '{8'h55, 10'b0101010101};
        vecs[4] = '{8'hA5, 10'b0101001011};
        vecs[5] = '{8'h80, 10'b0000000011};
        vecs[6] = '{8'h0A, 10'b0010100001};

        // Reset state.
        #2 rst_n = 1'b0;
        step();
        step();
        tx_en = 1'b1;
        #1;
        chk("rst_txd", int'(uart_txd), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_rd_en", int'(fifo_if.fifo_rd_en), 0);
        chk("rst_done", int'(byte_done), 0);
        step();
        rst_n = 1'b1;

        // Empty FIFO with tx_en high: no reads, line stays high.
        l0  = line_q.size();
        rd0 = rd_q.size();
        repeat (100) step();
        chk("empty_rd_pulses", rd_q.size() - rd0, 0);
        bad = 0;
        for (int i = l0; i < line_q.size(); i++) if (!line_q[i] || busy_q[i]) bad++;
        chk("empty_line_high", bad, 0);

        // Table-driven single frames.
        for (int i = 0; i < 7; i++) send_check(vecs[i].din, vecs[i].line);

        // tx_en dropped mid-frame (data bit 3).
        rd0 = rd_q.size();
        rx0 = rx_b.size();
        push(8'h55);
        push(8'h33);
        wait_rd(r, ok);
        chk("txen_rd_seen", int'(ok), 1);
        while (line_q.size() < r + 2 + CLKS * 4 + 1) step();
        tx_en = 1'b0;
        repeat (60) step();
        chk("txen_rx_cnt", rx_b.size() - rx0, 1);
        if (rx_b.size() > rx0) chk("txen_rx_byte", int'(rx_b[rx0]), 8'h55);
        chk("txen_rd_blocked", rd_q.size() - rd0, 1);
        chk("txen_fifo_kept", int'(fifo_if.fifo_empty), 0);
        tx_en = 1'b1;
        wait_rx(rx0 + 2, 150, ok);
        chk("txen_resume", int'(ok), 1);
        if (rx_b.size() > rx0 + 1) chk("txen_next_byte", int'(rx_b[rx0 + 1]), 8'h33);
        chk("txen_rd_total", rd_q.size() - rd0, 2);
        repeat (5) step();

        // fifo_dout corrupted after LOAD.
        rx0 = rx_b.size();
        push(8'h00);
        wait_rd(r, ok);
        step();
        corrupt = 1'b1;
        wait_rx(rx0 + 1, 100, ok);
        chk("corrupt_rx_seen", int'(ok), 1);
        if (rx_b.size() > rx0) chk("corrupt_rx_byte", int'(rx_b[rx0]), 8'h00);
        corrupt = 1'b0;
        repeat (5) step();

        // Reset pulsed during data bit 5.
        rd0 = rd_q.size();
        rx0 = rx_b.size();
        push(8'hC3);
        push(8'h5A);
        wait_rd(r, ok);
        chk("rstmid_rd_seen", int'(ok), 1);
        while (line_q.size() < r + 2 + CLKS * 6 + 1) step();
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_txd", int'(uart_txd), 1);
        chk("rstmid_busy", int'(tx_busy), 0);
        chk("rstmid_rd_en", int'(fifo_if.fifo_rd_en), 0);
        chk("rstmid_done", int'(byte_done), 0);
        repeat (3) step();
        rst_n = 1'b1;
        c = line_q.size();
        step();
        chk("rstmid_rd_total", rd_q.size() - rd0, 2);
        if (rd_q.size() > rd0) chk("rstmid_rd_cyc", rd_q[rd_q.size() - 1] - c, 0);
        wait_rx(rx0 + 1, 100, ok);
        chk("rstmid_rx_seen", int'(ok), 1);
        if (rx_b.size() > rx0) chk("rstmid_rx_byte", int'(rx_b[rx0]), 8'h5A);
        repeat (10) step();
        chk("rstmid_no_resend", rx_b.size() - rx0, 1);

        // 56-byte record, preloaded then streamed back-to-back.
        for (int i = 0; i < 56; i++) begin
            if (i < 3)           rec[i] = 8'h30;
            else if (i == 3)     rec[i] = 8'h31;
            else if (i == 55)    rec[i] = 8'h0A;
            else if (i % 5 == 4) rec[i] = 8'h2C;
            else                 rec[i] = 8'h30 + 8'(i % 10);
        end
        tx_en = 1'b0;
        rd0 = rd_q.size();
        rx0 = rx_b.size();
        for (int i = 0; i < 56; i++) push(rec[i]);
        step();
        tx_en = 1'b1;
        wait_rx(rx0 + 56, 56 * FRAME + 200, ok);
        chk("rec_complete", int'(ok), 1);
        repeat (5) step();
        chk("rec_rx_cnt", rx_b.size() - rx0, 56);
        chk("rec_rd_cnt", rd_q.size() - rd0, 56);
        if (rx_b.size() >= rx0 + 56) begin
            bad = 0;
            for (int i = 0; i < 56; i++) if (rx_b[rx0 + i] != rec[i]) bad++;
            chk("rec_bytes_bad", bad, 0);
            chk("rec_last_byte", int'(rx_b[rx0 + 55]), 8'h0A);
            chk("rec_spacing0", rx_s[rx0 + 1] - rx_s[rx0], FRAME);
            bad = 0;
            for (int i = 1; i < 56; i++) if (rx_s[rx0 + i] - rx_s[rx0 + i - 1] != FRAME) bad++;
            chk("rec_spacing_bad", bad, 0);
        end

        // Randomized traffic against an ordered byte-stream model.
        rd0 = rd_q.size();
        rx0 = rx_b.size();
        exp_q.delete();
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom_range(0, 255));
            push(b);
            exp_q.push_back(b);
            repeat ($urandom_range(0, 60)) step();
            tx_en = ($urandom_range(0, 3) != 0);
        end
        tx_en = 1'b1;
        wait_rx(rx0 + 30, 30 * FRAME + 300, ok);
        chk("rand_complete", int'(ok), 1);
        repeat (5) step();
        chk("rand_rx_cnt", rx_b.size() - rx0, 30);
        chk("rand_rd_cnt", rd_q.size() - rd0, 30);
        if (rx_b.size() >= rx0 + 30 && rd_q.size() >= rd0 + 30) begin
            bad = 0;
            for (int i = 0; i < 30; i++) if (rx_b[rx0 + i] != exp_q[i]) bad++;
            chk("rand_bytes_bad", bad, 0);
            bad = 0;
            for (int i = 0; i < 30; i++) if (rx_s[rx0 + i] != rd_q[rd0 + i] + 2) bad++;
            chk("rand_start_align_bad", bad, 0);
            minsp = 1000000;
            for (int i = 1; i < 30; i++)
                if (rx_s[rx0 + i] - rx_s[rx0 + i - 1] < minsp) minsp = rx_s[rx0 + i] - rx_s[rx0 + i - 1];
            chk("rand_min_spacing_ok", int'(minsp >= FRAME), 1);
        end

        chk("frame_errors", frame_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global bound on simulation time.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit (%0d/%0d checks passed so far)", n_pass, n_chk);
        $fatal(1, "watchdog timeout");
    end

endmodule
